// File: rtl/teletext_dprintf_pkg.sv
// Shared types, control-byte codes and the nibble-to-ASCII helper for teletext_dprintf.
// Defining TELETEXT_DPRINTF_HEX_EN adds the HEX_LO state used for 0x80 hex escapes.
package teletext_dprintf_pkg;

`ifdef TELETEXT_DPRINTF_HEX_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HEX_LO = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1
  } state_t;
`endif

  localparam logic [7:0] CODE_END  = 8'h00;
  localparam logic [7:0] CODE_SKIP = 8'hFF;
  localparam logic [7:0] CODE_HEX  = 8'h80;

  // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/teletext_dprintf_if.sv
// Request / display-SRAM write bundle for teletext_dprintf, plus FSM state for observation.
// Handshake: upstream raises req__valid and holds it with stable payload until it sees the
// one-cycle ack pulse; the request is captured on the edge that raises ack.
interface teletext_dprintf_if;
  import teletext_dprintf_pkg::*;

  logic        req__valid;
  logic [15:0] req__address;
  logic [63:0] req__data_0;
  logic [63:0] req__data_1;
  logic        ack;
  logic        sram_write__enable;
  logic [15:0] sram_write__address;
  logic [7:0]  sram_write__data;
  logic        busy;
  state_t      state;

  modport master (
    output req__valid, req__address, req__data_0, req__data_1,
    input  ack, sram_write__enable, sram_write__address, sram_write__data, busy, state
  );

  modport slave (
    input  req__valid, req__address, req__data_0, req__data_1,
    output ack, sram_write__enable, sram_write__address, sram_write__data, busy, state
  );
endinterface

// File: rtl/teletext_dprintf.sv
// Writes up to 16 captured character bytes into display SRAM, one byte per cycle,
// honouring END/SKIP codes; TELETEXT_DPRINTF_HEX_EN enables 0x80 two-digit hex escapes.
module teletext_dprintf
  import teletext_dprintf_pkg::*;
(
  input logic               clk,
  input logic               reset,
  teletext_dprintf_if.slave bus
);

  state_t       state;
  logic         ack_q;
  logic         wr_en;
  logic [15:0]  wr_addr;
  logic [7:0]   wr_data;
  logic [127:0] buffer;
  logic [15:0]  addr;
  logic [3:0]   idx;
  logic [7:0]   cur;

  // Byte 0 sits in the top bits, so byte n starts at bit 8*(15-n); ~idx == 15-idx.
  assign cur = buffer[{~idx, 3'b000} +: 8];

`ifdef TELETEXT_DPRINTF_HEX_EN
  logic [3:0] idx_nxt;
  logic [7:0] nxt;
  assign idx_nxt = idx + 4'd1;
  assign nxt     = buffer[{~idx_nxt, 3'b000} +: 8];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= 16'h0000;
      wr_data <= 8'h00;
      buffer  <= '0;
      addr    <= 16'h0000;
      idx     <= 4'd0;
    end else begin
      ack_q <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          // ack is still high in the cycle after capture while upstream valid lingers.
          if (bus.req__valid && !ack_q) begin
            buffer <= {bus.req__data_0, bus.req__data_1};
            addr   <= bus.req__address;
            idx    <= 4'd0;
            ack_q  <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cur == CODE_END) begin
            state <= IDLE;
          end else if (cur == CODE_SKIP) begin
            addr <= addr + 16'd1;
            if (idx == 4'd15) state <= IDLE;
            else              idx   <= idx + 4'd1;
`ifdef TELETEXT_DPRINTF_HEX_EN
          end else if (cur == CODE_HEX) begin
            if (idx == 4'd15) begin
              state <= IDLE;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= hex_ascii(nxt[7:4]);
              addr    <= addr + 16'd1;
              idx     <= idx_nxt;
              state   <= HEX_LO;
            end
`endif
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= cur;
            addr    <= addr + 16'd1;
            if (idx == 4'd15) state <= IDLE;
            else              idx   <= idx + 4'd1;
          end
        end
`ifdef TELETEXT_DPRINTF_HEX_EN
        HEX_LO: begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= hex_ascii(cur[3:0]);
          addr    <= addr + 16'd1;
          if (idx == 4'd15) state <= IDLE;
          else begin
            idx   <= idx + 4'd1;
            state <= BUSY;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack                 = ack_q;
  assign bus.sram_write__enable  = wr_en;
  assign bus.sram_write__address = wr_addr;
  assign bus.sram_write__data    = wr_data;
  assign bus.busy                = (state != IDLE);
  assign bus.state               = state;

endmodule

// File: doc/teletext_dprintf.md
TELETEXT_DPRINTF -- requirements
Module: teletext_dprintf

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req__valid  input  1  dprintf request present; held until acked.
REQ-005 req__address  input  16  display SRAM address of first character.
REQ-006 req__data_0  input  64  bytes 0..7; byte 0 = bits[63:56].
REQ-007 req__data_1  input  64  bytes 8..15; byte 15 = bits[7:0].
REQ-008 ack  output  1  registered one-cycle pulse; request captured.
REQ-009 sram_write__enable  output  1  registered display SRAM write strobe.
REQ-010 sram_write__address  output  16  write address.
REQ-011 sram_write__data  output  8  character byte.
REQ-012 busy  output  1  high while not IDLE.

Function
REQ-013 States SHALL be IDLE, BUSY, HEX_LO.
REQ-014 IDLE: if req__valid && !ack, SHALL capture 16 data bytes and address, set byte index 0, assert ack next cycle, go BUSY.
REQ-015 SHALL NOT accept a request in a cycle where ack is high, because the upstream valid is still high that cycle.
REQ-016 BUSY processes one byte per cycle, and the write is visible the following cycle. First write appears 2 cycles after the accepting edge.
REQ-017 Byte 0x00 SHALL end the request with no write; go IDLE.
REQ-018 Byte 0xFF SHALL skip: no write, address +1.
REQ-019 Any other byte (except 0x80 when hex is enabled) SHALL be written at the current address; address +1.
REQ-020 After processing byte 15, the block SHALL go IDLE.
REQ-021 Address arithmetic SHALL be 16-bit modulo; 0xFFFF+1 = 0x0000.
REQ-022 sram_write__enable SHALL be high only in cycles carrying a write. Address and data are don't-care otherwise.
REQ-023 New requests SHALL be ignored while busy. The upstream holds its request until ack.

Reset
REQ-024 On reset, state SHALL be IDLE, and ack, sram_write__enable and busy SHALL be 0. Address, data and buffer SHALL be 0.
REQ-025 Reset mid-request SHALL abandon the request with no further writes and no ack.

Configuration
REQ-026 With TELETEXT_DPRINTF_HEX_EN defined, byte 0x80 followed by byte B SHALL write ASCII hex of B[7:4] at the current address (BUSY). It SHALL then write B[3:0] at address+1 (HEX_LO), consuming both bytes, with address +2.
REQ-027 Hex digits SHALL be uppercase ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46). B = 0x00 is printed, not treated as a terminator.
REQ-028 With HEX_EN defined, if 0x80 is byte 15, the block SHALL make no write and go IDLE.
REQ-029 Without TELETEXT_DPRINTF_HEX_EN, 0x80 SHALL be an ordinary byte, HEX_LO SHALL not exist, and busy timing SHALL follow REQ-016..020 only.

Structure
REQ-030 Package teletext_dprintf_pkg SHALL hold the state enum, the code constants (END 0x00, SKIP 0xFF, HEX 0x80) and the nibble-to-ASCII function.
REQ-031 The design SHALL have no sub-module; byte select SHALL be an index mux on the 128-bit buffer.

Verification
REQ-032 Request addr 0x0100, data_0 = "HELLO\0.." -> ack pulse 1 cycle; writes H,E,L,L,O to 0x0100-0x0104 on consecutive cycles; idle after 0x00.
REQ-033 16 non-zero bytes at addr 0xFFFE -> 16 writes; addresses 0xFFFE, 0xFFFF, 0x0000..0x000D; busy drops after byte 15.
REQ-034 Bytes 'A',0xFF,'B',0x00 at 0x0200 -> writes 'A'@0x0200, 'B'@0x0202; nothing @0x0201.
REQ-035 HEX_EN: bytes 0x80,0x3C,'!',0x00 at 0x0300 -> '3'@0x0300, 'C'@0x0301, '!'@0x0302. Without the macro: 0x80, 0x3C, '!' written at 0x0300-0x0302.
REQ-036 Hold req__valid high through ack, then drop it -> exactly one acceptance. A second request presented while busy -> acked only after return to IDLE.
REQ-037 Assert reset after the 3rd write of a 10-character request -> no further writes; ack=0, busy=0 next cycle; next request processed normally.
